// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned DEFAULT_MAX_WORDS = 256;
  localparam int unsigned BYTES_PER_WORD    = 4;

endpackage

// File: rtl/imem_boot_loader_assembler.sv
// Big-endian byte-to-word assembler with running XOR checksum of payload bytes.
module boot_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [7:0]  checksum,
  output logic        word_complete
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shift;
  logic [1:0]  byte_count;

  // The completed word includes the byte being accepted this cycle.
  assign word          = {shift, data};
  assign word_complete = load && (byte_count == LAST_BYTE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      byte_count <= '0;
      checksum   <= '0;
    end else if (clear) begin
      shift      <= '0;
      byte_count <= '0;
      checksum   <= '0;
    end else if (load) begin
      shift      <= {shift[15:0], data};
      byte_count <= byte_count + 2'd1;
      checksum   <= checksum ^ data;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory and
// holds the core in reset until the image is verified.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, next_state;
  logic        take, asm_load, asm_clear, clear_words, word_complete, last_word;
  logic [31:0] word;
  logic [7:0]  checksum, len_hi;
  logic [15:0] len, len_in;

  assign take      = in_valid && in_ready;
  assign len_in    = {len_hi, in_data};
  assign in_ready  = state inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  // Completions are >=4 cycles apart, so words_loaded is already current here.
  assign last_word = (words_loaded + 16'd1) == len;

  boot_word_assembler u_asm (
    .clock         (clock),
    .reset         (reset),
    .clear         (asm_clear),
    .load          (asm_load),
    .data          (in_data),
    .word          (word),
    .checksum      (checksum),
    .word_complete (word_complete)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LEN_HI;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    asm_load    = 1'b0;
    asm_clear   = 1'b0;
    clear_words = 1'b0;
    unique case (state)
      LEN_HI: if (take) next_state = LEN_LO;
      LEN_LO: if (take) begin
        asm_clear = 1'b1;
        if ({1'b0, len_in} > MAX_N) next_state = ERROR;
        else if (len_in == '0)      next_state = CSUM;
        else                        next_state = DATA;
      end
      DATA: if (take) begin
        asm_load = 1'b1;
        if (word_complete && last_word) next_state = CSUM;
      end
      CSUM: if (take) next_state = (in_data == checksum) ? DONE : ERROR;
      DONE, ERROR: if (restart) begin
        next_state  = LEN_HI;
        asm_clear   = 1'b1;
        clear_words = 1'b1;
      end
      default: next_state = LEN_HI;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_hi       <= '0;
      len          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      core_reset   <= 1'b1;
    end else begin
      if (state == LEN_HI && take) len_hi <= in_data;
      if (state == LEN_LO && take) len    <= len_in;
      imem_we <= word_complete;
      if (word_complete) begin
        imem_wdata <= word;
        imem_addr  <= ADDR_W'(words_loaded) * ADDR_W'(BYTES_PER_WORD);
      end
      if (clear_words)  words_loaded <= '0;
      else if (imem_we) words_loaded <= words_loaded + 16'd1;
      core_reset <= (state != DONE);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed table plus random streams for the boot loader, checked against a
// stream-parsing reference model.
module tb_imem_boot_loader;

  localparam int MAXW = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_boot_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [63:0] got[$];
  logic [63:0] exp_w[$];

  always @(negedge clock)
    if (!reset && imem_we) got.push_back({imem_addr, imem_wdata});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: parse the byte stream with plain arithmetic.
  task automatic model(output logic m_done, output logic m_err, output int m_words);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_w.delete();
    n = {stream[0], stream[1]};
    m_done = 0; m_err = 0; m_words = 0;
    if (n > MAXW) begin m_err = 1; return; end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
      x = x ^ stream[2+4*i] ^ stream[3+4*i] ^ stream[4+4*i] ^ stream[5+4*i];
      exp_w.push_back({32'(4*i), w});
    end
    m_words = n;
    if (stream[2+4*n] == x) m_done = 1; else m_err = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && tries < 20) begin @(negedge clock); tries++; end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_restart_if_needed();
    if (done || error) begin
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic run_stream(input int gap);
    pulse_restart_if_needed();
    got.delete();
    foreach (stream[i]) send_byte(stream[i], gap);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_result(input string tag, input logic e_done, input logic e_err, input int e_words);
    check({tag, ".done"}, 64'(done), 64'(e_done));
    check({tag, ".error"}, 64'(error), 64'(e_err));
    check({tag, ".core_reset"}, 64'(core_reset), 64'(!e_done));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(!(e_done || e_err)));
    check({tag, ".words_loaded"}, 64'(words_loaded), 64'(e_words));
    check({tag, ".nwrites"}, 64'(got.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      check({tag, ".write"}, got[i], exp_w[i]);
  endtask

  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           nbytes;
    int           gap;
    logic         e_done;
    logic         e_err;
    int           e_words;
  } vec_t;

  vec_t vecs[6];
  logic m_d, m_e;
  int   m_n;

  initial begin
    vecs[0] = '{"happy",     {88'h0002200000048C010000A9, 40'h0}, 11, 0, 1, 0, 2};
    vecs[1] = '{"csum_fail", {88'h0002200000048C010000A8, 40'h0}, 11, 0, 0, 1, 2};
    vecs[2] = '{"zero_len",  {24'h000000, 104'h0},                 3, 0, 1, 0, 0};
    vecs[3] = '{"oversize",  {16'h0101, 112'h0},                   2, 0, 0, 1, 0};
    vecs[4] = '{"after_err", {88'h0002200000048C010000A9, 40'h0}, 11, 0, 1, 0, 2};
    vecs[5] = '{"gapped",    {88'h0002200000048C010000A9, 40'h0}, 11, 3, 1, 0, 2};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; restart = 1'b0;
    repeat (2) @(negedge clock);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.core_reset", 64'(core_reset), 64'd1);
    check("rst.imem_we", 64'(imem_we), 64'd0);
    check("rst.done_error", 64'({done, error}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[v]) begin
      stream.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) stream.push_back(vecs[v].bytes[127-8*i -: 8]);
      model(m_d, m_e, m_n);
      run_stream(vecs[v].gap);
      check_result(vecs[v].name, vecs[v].e_done, vecs[v].e_err, vecs[v].e_words);
      if (v == 0 && got.size() == 2) begin
        check("happy.w0", got[0], 64'h00000000_20000004);
        check("happy.w1", got[1], 64'h00000004_8C010000);
      end
    end

    // Reset part-way through the payload.
    pulse_restart_if_needed();
    got.delete();
    stream.delete();
    for (int i = 0; i < 8; i++) stream.push_back(vecs[0].bytes[127-8*i -: 8]);
    foreach (stream[i]) send_byte(stream[i], 0);
    check("midrst.first_word_written", 64'(got.size()), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst.outs", {imem_we, imem_addr, imem_wdata[30:0]}, 64'd0);
    check("midrst.wdata_msb", 64'(imem_wdata[31]), 64'd0);
    check("midrst.status", 64'({in_ready, core_reset, done, error}), 64'b1100);
    check("midrst.words", 64'(words_loaded), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    stream.delete();
    for (int i = 0; i < 11; i++) stream.push_back(vecs[0].bytes[127-8*i -: 8]);
    model(m_d, m_e, m_n);
    run_stream(0);
    check_result("midrst.reload", m_d, m_e, m_n);

    // Random streams against the model.
    for (int t = 0; t < 24; t++) begin
      int n, r;
      logic [7:0] x;
      stream.delete();
      r = $urandom_range(0, 7);
      n = (r == 0) ? MAXW + 1 + $urandom_range(0, 300) : $urandom_range(0, 5);
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      if (n <= MAXW) begin
        x = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
          stream.push_back(8'($urandom));
          x = x ^ stream[stream.size()-1];
        end
        stream.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
      end
      model(m_d, m_e, m_n);
      if (m_e) m_n = exp_w.size();
      run_stream($urandom_range(0, 2));
      check_result("random", m_d, m_e, m_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
